// File: rtl/play_mode_scheduler_if.sv
// Signal bundle between the play-mode scheduler and its surroundings:
// mode requests and per-mode frequencies in, enables/frequency/status out.
interface play_mode_scheduler_if #(
   parameter int unsigned FREQ_W = 11
);
   logic [1:0]        mode_sel;
   logic              mode_go;
   logic [FREQ_W-1:0] free_freq;
   logic [FREQ_W-1:0] auto_freq;
   logic [FREQ_W-1:0] learn_freq;
   logic              auto_done;
   logic              en_free;
   logic              en_auto;
   logic              en_learn;
   logic [FREQ_W-1:0] frequency;
   logic [1:0]        mode;
   logic              busy;

   modport master (
      output mode_sel, mode_go, free_freq, auto_freq, learn_freq, auto_done,
      input  en_free, en_auto, en_learn, frequency, mode, busy
   );

   modport slave (
      input  mode_sel, mode_go, free_freq, auto_freq, learn_freq, auto_done,
      output en_free, en_auto, en_learn, frequency, mode, busy
   );
endinterface

// File: rtl/play_mode_scheduler.sv
// Grants the single tone generator to one of free/auto/learn play, inserting
// a silent gap of MUTE_CYCLES cycles on every mode change.
module play_mode_scheduler #(
   parameter int unsigned FREQ_W      = 11,
   parameter int unsigned MUTE_CYCLES = 100000
) (
   input logic                  clk,
   input logic                  reset,
   play_mode_scheduler_if.slave bus
);

   localparam int unsigned CNT_W = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUTE_CYCLES - 1);

   localparam logic [1:0] M_IDLE  = 2'b00;
   localparam logic [1:0] M_FREE  = 2'b01;
   localparam logic [1:0] M_AUTO  = 2'b10;
   localparam logic [1:0] M_LEARN = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FREE,
      S_AUTO,
      S_LEARN,
      S_MUTE
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        target_q, target_d;
   logic [1:0]        mode_q, mode_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FREQ_W-1:0] freq_q, freq_d;

   function automatic state_t mode_to_state(input logic [1:0] m);
      case (m)
         M_FREE:  return S_FREE;
         M_AUTO:  return S_AUTO;
         M_LEARN: return S_LEARN;
         default: return S_IDLE;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      freq_d   = '0;

      case (state_q)
         S_MUTE: begin
            if (bus.mode_go) begin
               target_d = bus.mode_sel;
               cnt_d    = CNT_LOAD;
            end else if (cnt_q == '0) begin
               state_d = mode_to_state(target_q);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_IDLE, S_FREE, S_AUTO, S_LEARN: begin
            // outside MUTE, mode_q always names the current state
            if (bus.mode_go) begin
               if (bus.mode_sel != mode_q) begin
                  target_d = bus.mode_sel;
                  cnt_d    = CNT_LOAD;
                  state_d  = S_MUTE;
               end
            end else if (state_q == S_AUTO && bus.auto_done) begin
               target_d = M_IDLE;
               cnt_d    = CNT_LOAD;
               state_d  = S_MUTE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q == S_MUTE && state_d != S_MUTE) begin
         mode_d = target_q;
      end

      // a source passes only while its mode stays active, so the word drops
      // to zero on the same edge that the enable falls
      if (state_d == state_q) begin
         case (state_q)
            S_FREE:  freq_d = bus.free_freq;
            S_AUTO:  freq_d = bus.auto_freq;
            S_LEARN: freq_d = bus.learn_freq;
            default: freq_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         target_q <= M_IDLE;
         mode_q   <= M_IDLE;
         cnt_q    <= '0;
         freq_q   <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         freq_q   <= freq_d;
      end
   end

   assign bus.en_free   = (state_q == S_FREE);
   assign bus.en_auto   = (state_q == S_AUTO);
   assign bus.en_learn  = (state_q == S_LEARN);
   assign bus.busy      = (state_q == S_MUTE);
   assign bus.mode      = mode_q;
   assign bus.frequency = freq_q;

endmodule

// File: tb/tb_play_mode_scheduler.sv
// Directed bench for play_mode_scheduler with MUTE_CYCLES=4: expected output
// snapshots are queued per step and compared at the following negedge.
module tb_play_mode_scheduler;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   play_mode_scheduler_if #(.FREQ_W(11)) bus ();

   play_mode_scheduler #(.FREQ_W(11), .MUTE_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [10:0] freq;
      logic [2:0]  en;    // {learn, auto, free}
      logic [1:0]  mode;
      logic        busy;
   } exp_t;

   exp_t sb[$];

   task automatic push(input string tag, input logic [10:0] f, input logic [2:0] en,
                       input logic [1:0] m, input logic b);
      exp_t e;
      e.tag = tag; e.freq = f; e.en = en; e.mode = m; e.busy = b;
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t       e;
      logic [2:0] en_obs;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: no expected entry queued");
         return;
      end
      e = sb.pop_front();
      en_obs = {bus.en_learn, bus.en_auto, bus.en_free};
      assert ({bus.frequency, en_obs, bus.mode, bus.busy} === {e.freq, e.en, e.mode, e.busy})
      else begin
         errors++;
         $error("FAIL %s: got freq=%0d en=%b mode=%b busy=%b, expected freq=%0d en=%b mode=%b busy=%b",
                e.tag, bus.frequency, en_obs, bus.mode, bus.busy, e.freq, e.en, e.mode, e.busy);
      end
      checks++;
      assert ($onehot0(en_obs))
      else begin
         errors++;
         $error("FAIL onehot_%s: got en=%b, expected at most one bit set", e.tag, en_obs);
      end
   endtask

   // one clock edge, then compare at the following negedge
   task automatic step(input string tag, input logic [10:0] f, input logic [2:0] en,
                       input logic [1:0] m, input logic b);
      push(tag, f, en, m, b);
      @(posedge clk);
      @(negedge clk);
      check_now();
   endtask

   initial begin
      #100000;
      errors++;
      $error("FAIL timeout: bench did not finish, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      bus.mode_sel   = 2'b00;
      bus.mode_go    = 1'b0;
      bus.auto_done  = 1'b0;
      bus.free_freq  = 11'd523;
      bus.auto_freq  = 11'd523;
      bus.learn_freq = 11'd523;

      // reset held with live sources
      #1;
      push("reset_async", 11'd0, 3'b000, 2'b00, 1'b0);
      check_now();
      @(negedge clk);
      step("reset_hold", 11'd0, 3'b000, 2'b00, 1'b0);
      bus.mode_sel = 2'b01;
      bus.mode_go  = 1'b1;
      step("reset_ignores_go", 11'd0, 3'b000, 2'b00, 1'b0);
      bus.mode_go  = 1'b0;
      reset = 1'b1;
      bus.free_freq = 11'd262;
      step("idle", 11'd0, 3'b000, 2'b00, 1'b0);

      // IDLE -> FREE through the full gap
      bus.mode_sel = 2'b01;
      bus.mode_go  = 1'b1;
      step("to_free_mute1", 11'd0, 3'b000, 2'b00, 1'b1);
      bus.mode_go  = 1'b0;
      step("to_free_mute2", 11'd0, 3'b000, 2'b00, 1'b1);
      step("to_free_mute3", 11'd0, 3'b000, 2'b00, 1'b1);
      step("to_free_mute4", 11'd0, 3'b000, 2'b00, 1'b1);
      step("free_enter", 11'd0, 3'b001, 2'b01, 1'b0);
      step("free_freq", 11'd262, 3'b001, 2'b01, 1'b0);

      // isolation of inactive sources
      bus.auto_freq  = 11'd440;
      bus.learn_freq = 11'd330;
      step("iso_a", 11'd262, 3'b001, 2'b01, 1'b0);
      step("iso_b", 11'd262, 3'b001, 2'b01, 1'b0);
      bus.free_freq = 11'd294;
      step("free_change", 11'd294, 3'b001, 2'b01, 1'b0);

      // same-mode request is a no-op
      bus.mode_sel = 2'b01;
      bus.mode_go  = 1'b1;
      step("same_mode_a", 11'd294, 3'b001, 2'b01, 1'b0);
      bus.mode_go  = 1'b0;
      step("same_mode_b", 11'd294, 3'b001, 2'b01, 1'b0);

      // retarget during MUTE: AUTO requested, then LEARN two cycles later
      bus.mode_sel = 2'b10;
      bus.mode_go  = 1'b1;
      step("retgt_m1", 11'd0, 3'b000, 2'b01, 1'b1);
      bus.mode_go  = 1'b0;
      step("retgt_m2", 11'd0, 3'b000, 2'b01, 1'b1);
      bus.mode_sel = 2'b11;
      bus.mode_go  = 1'b1;
      step("retgt_r1", 11'd0, 3'b000, 2'b01, 1'b1);
      bus.mode_go  = 1'b0;
      step("retgt_r2", 11'd0, 3'b000, 2'b01, 1'b1);
      step("retgt_r3", 11'd0, 3'b000, 2'b01, 1'b1);
      step("retgt_r4", 11'd0, 3'b000, 2'b01, 1'b1);
      step("learn_enter", 11'd0, 3'b100, 2'b11, 1'b0);
      step("learn_freq", 11'd330, 3'b100, 2'b11, 1'b0);

      // LEARN -> AUTO, then song end returns to IDLE
      bus.auto_freq = 11'd392;
      bus.mode_sel  = 2'b10;
      bus.mode_go   = 1'b1;
      step("to_auto_m1", 11'd0, 3'b000, 2'b11, 1'b1);
      bus.mode_go   = 1'b0;
      for (int i = 0; i < 3; i++) step("to_auto_m", 11'd0, 3'b000, 2'b11, 1'b1);
      step("auto_enter", 11'd0, 3'b010, 2'b10, 1'b0);
      step("auto_freq", 11'd392, 3'b010, 2'b10, 1'b0);
      bus.auto_done = 1'b1;
      step("song_end_m1", 11'd0, 3'b000, 2'b10, 1'b1);
      bus.auto_done = 1'b0;
      for (int i = 0; i < 3; i++) step("song_end_m", 11'd0, 3'b000, 2'b10, 1'b1);
      step("song_end_idle", 11'd0, 3'b000, 2'b00, 1'b0);

      // auto_done and mode_go together: the request wins
      bus.mode_sel = 2'b10;
      bus.mode_go  = 1'b1;
      step("re_auto_m1", 11'd0, 3'b000, 2'b00, 1'b1);
      bus.mode_go  = 1'b0;
      for (int i = 0; i < 3; i++) step("re_auto_m", 11'd0, 3'b000, 2'b00, 1'b1);
      step("re_auto_enter", 11'd0, 3'b010, 2'b10, 1'b0);
      step("re_auto_freq", 11'd392, 3'b010, 2'b10, 1'b0);
      bus.auto_done = 1'b1;
      bus.mode_sel  = 2'b11;
      bus.mode_go   = 1'b1;
      step("both_m1", 11'd0, 3'b000, 2'b10, 1'b1);
      bus.auto_done = 1'b0;
      bus.mode_go   = 1'b0;
      for (int i = 0; i < 3; i++) step("both_m", 11'd0, 3'b000, 2'b10, 1'b1);
      step("both_learn", 11'd0, 3'b100, 2'b11, 1'b0);
      step("both_learn_freq", 11'd330, 3'b100, 2'b11, 1'b0);

      // asynchronous reset mid-mode
      #3 reset = 1'b0;
      #1;
      push("reset_mid_mode", 11'd0, 3'b000, 2'b00, 1'b0);
      check_now();
      @(negedge clk);
      reset = 1'b1;
      step("post_reset_idle", 11'd0, 3'b000, 2'b00, 1'b0);

      // asynchronous reset mid-MUTE discards the pending target
      bus.mode_sel = 2'b01;
      bus.mode_go  = 1'b1;
      step("pre_reset_mute", 11'd0, 3'b000, 2'b00, 1'b1);
      bus.mode_go  = 1'b0;
      #2 reset = 1'b0;
      #1;
      push("reset_mid_mute", 11'd0, 3'b000, 2'b00, 1'b0);
      check_now();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) step("target_discarded", 11'd0, 3'b000, 2'b00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
